regfile_port_arbiter: RTL
=========================

// Module: regfile_port_arbiter
// PURPOSE
//  Shares one port of the 16x8 negedge-clocked register file between two requesters:
//  A = I2C slave side, B = SPI master side. Round-robin arbitration, 1..16 beat bursts
//  with address auto-increment, and per-beat ack/rvalid handshakes. Sits between the
//  protocol engines and the register file; the file's second port stays free.
// PARAMETERS
//  AW       4        address width (register file depth 2**AW)
//  DW       8        data width
//  WP_MASK  16'h0000 bit n=1: address n write-protected against requester B (macro only)
// PORTS
//  i_ck         in   1   clock; all state on rising edge
//  i_rstn       in   1   reset, asynchronous, active-low
//  i_req_a/b    in   1   request; hold high until o_done_x
//  i_rw_a/b     in   1   0:write 1:read; sampled at grant
//  i_addr_a/b   in   AW  burst start address; sampled at grant
//  i_len_a/b    in   4   beats-1; sampled at grant
//  i_wdata_a/b  in   DW  write data for current beat
//  o_gnt_a/b    out  1   requester owns the port
//  o_ack_a/b    out  1   beat issued; write data consumed this cycle
//  o_rvalid_a/b out  1   o_rdata_x valid (read beats only)
//  o_rdata_a/b  out  DW  read data
//  o_done_a/b   out  1   one-cycle pulse, burst complete
//  o_err_a/b    out  1   one-cycle pulse, write beat suppressed (macro only)
//  o_mem_csn    out  1   to register file csn
//  o_mem_rw     out  1   to register file rw
//  o_mem_addr   out  AW  to register file address
//  o_mem_wdata  out  DW  to register file write data
//  i_mem_rdata  in   DW  from register file read data
// BEHAVIOUR
//  - Reset: state IDLE; all o_gnt/ack/rvalid/done/err=0; o_rdata_x=0; o_mem_csn=1;
//    o_mem_rw=1; o_mem_addr=0; o_mem_wdata=0; RR pointer favours A.
//  - FSM IDLE -> ISSUE -> GAP -> (ISSUE | IDLE). One beat per 2 cycles.
//  - IDLE: at rising edge with any req high, grant registered; o_gnt_x visible the next
//    cycle (state ISSUE). rw, addr, len latched at this edge. Both requesting: grant
//    winner of RR pointer; pointer then points at the other requester.
//  - ISSUE: o_mem_csn=0, o_mem_rw=latched rw, o_mem_addr=beat address,
//    o_mem_wdata=i_wdata_x of granted side (combinational mux from registered grant);
//    o_ack_x=1. Memory captures on falling edge mid-cycle.
//  - GAP: o_mem_csn=1. For read beats o_rdata_x <= i_mem_rdata at edge ending ISSUE;
//    o_rvalid_x=1 during GAP. Address increments mod 16 (15 -> 0 wraps).
//    Beat counter 0 -> GAP of last beat: o_done_x=1, next state IDLE, o_gnt_x drops.
//  - Abort: req_x low at edge ending GAP (not last beat) -> IDLE, no o_done_x, no further
//    access; RR pointer still advances. Req low during ISSUE ignored until GAP end.
//  - Non-granted requester outputs held 0; o_rdata_x holds last value.
//  - Back-to-back: after done, IDLE lasts exactly one cycle before next ISSUE.
//  - Async reset mid-burst: immediate return to reset state, o_mem_csn=1 same instant.
// CONFIGURATION
//  REGFILE_ARB_WPROT_EN defined: B write beat to address n with WP_MASK[n]=1 issues
//    o_mem_csn=1 in its ISSUE cycle, o_ack_b=1, o_err_b=1; burst continues. A unaffected.
//  Undefined: WP_MASK ignored, o_err_a/b tied 0, all writes issued.
// TESTING
//  - Reset: drive reqs high during i_rstn=0 -> all outputs at reset values, csn=1.
//  - A write len=3 addr=4 data 11,22,33,44 -> csn low on 4 ISSUE cycles, addr 4..7,
//    4 acks, done after 8 cycles; B read same -> rvalid data 11,22,33,44.
//  - A and B request same edge from reset -> A first, B granted 1 IDLE cycle after A done;
//    repeat -> B wins next tie.
//  - B read len=15 addr=14 -> addresses 14,15,0..13, 16 rvalids, one done.
//  - A drops req after beat 2 of len=7 -> IDLE after that GAP, no done, B granted next.
//  - Macro on, WP_MASK=16'h0001, B writes 8'hAA addr 0 -> csn stays 1, o_err_b=1, reg 0 unchanged.

Source files
------------

// File: rtl/regfile_port_arbiter_if.sv
// rtl/regfile_port_arbiter_if.sv - requester, response and register-file signals of the port arbiter
interface regfile_port_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    // requester A (I2C slave side)
    logic          i_req_a;
    logic          i_rw_a;
    logic [AW-1:0] i_addr_a;
    logic [3:0]    i_len_a;
    logic [DW-1:0] i_wdata_a;
    logic          o_gnt_a;
    logic          o_ack_a;
    logic          o_rvalid_a;
    logic [DW-1:0] o_rdata_a;
    logic          o_done_a;
    logic          o_err_a;

    // requester B (SPI master side)
    logic          i_req_b;
    logic          i_rw_b;
    logic [AW-1:0] i_addr_b;
    logic [3:0]    i_len_b;
    logic [DW-1:0] i_wdata_b;
    logic          o_gnt_b;
    logic          o_ack_b;
    logic          o_rvalid_b;
    logic [DW-1:0] o_rdata_b;
    logic          o_done_b;
    logic          o_err_b;

    // shared register file port
    logic          o_mem_csn;
    logic          o_mem_rw;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [DW-1:0] i_mem_rdata;

    // arbiter side
    modport slave (
        input  i_req_a, i_rw_a, i_addr_a, i_len_a, i_wdata_a,
        output o_gnt_a, o_ack_a, o_rvalid_a, o_rdata_a, o_done_a, o_err_a,
        input  i_req_b, i_rw_b, i_addr_b, i_len_b, i_wdata_b,
        output o_gnt_b, o_ack_b, o_rvalid_b, o_rdata_b, o_done_b, o_err_b,
        output o_mem_csn, o_mem_rw, o_mem_addr, o_mem_wdata,
        input  i_mem_rdata
    );

    // requester / register file side
    modport master (
        output i_req_a, i_rw_a, i_addr_a, i_len_a, i_wdata_a,
        input  o_gnt_a, o_ack_a, o_rvalid_a, o_rdata_a, o_done_a, o_err_a,
        output i_req_b, i_rw_b, i_addr_b, i_len_b, i_wdata_b,
        input  o_gnt_b, o_ack_b, o_rvalid_b, o_rdata_b, o_done_b, o_err_b,
        input  o_mem_csn, o_mem_rw, o_mem_addr, o_mem_wdata,
        output i_mem_rdata
    );
endinterface

// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - round-robin burst arbiter for one register file port (option: REGFILE_ARB_WPROT_EN)
module regfile_port_arbiter #(
    parameter int               AW      = 4,
    parameter int               DW      = 8,
    parameter logic [2**AW-1:0] WP_MASK = '0
) (
    input  logic                  i_ck,
    input  logic                  i_rstn,
    regfile_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;   // 0: A, 1: B
    logic          rr_q, rr_d;         // tie winner: 0: A, 1: B
    logic          rw_q, rw_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    cnt_q, cnt_d;       // beats remaining after the current one
    logic [DW-1:0] rdata_a_q, rdata_b_q;
    logic          req_own;
    logic          wp_block;

    assign req_own = owner_q ? bus.i_req_b : bus.i_req_a;

`ifdef REGFILE_ARB_WPROT_EN
    // B write beats to protected addresses are acknowledged but never reach the file
    assign wp_block = owner_q && !rw_q && WP_MASK[addr_q];
`else
    logic unused_wp_mask;
    assign unused_wp_mask = ^WP_MASK;
    assign wp_block       = 1'b0;
`endif

    // burst state registers; async reset drops csn through the combinational outputs
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            rw_q    <= 1'b1;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // read data captured at the edge ending a read ISSUE; holds until the next read of that side
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else if (state_q == S_ISSUE && rw_q) begin
            if (owner_q) rdata_b_q <= bus.i_mem_rdata;
            else         rdata_a_q <= bus.i_mem_rdata;
        end
    end

    assign bus.o_rdata_a = rdata_a_q;
    assign bus.o_rdata_b = rdata_b_q;

    // next-state, grant selection and per-state outputs
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        rr_d            = rr_q;
        rw_d            = rw_q;
        addr_d          = addr_q;
        cnt_d           = cnt_q;
        bus.o_gnt_a     = 1'b0;
        bus.o_gnt_b     = 1'b0;
        bus.o_ack_a     = 1'b0;
        bus.o_ack_b     = 1'b0;
        bus.o_rvalid_a  = 1'b0;
        bus.o_rvalid_b  = 1'b0;
        bus.o_done_a    = 1'b0;
        bus.o_done_b    = 1'b0;
        bus.o_err_a     = 1'b0;
        bus.o_err_b     = 1'b0;
        bus.o_mem_csn   = 1'b1;
        bus.o_mem_rw    = 1'b1;
        bus.o_mem_addr  = '0;
        bus.o_mem_wdata = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_req_a || bus.i_req_b) begin
                    if (bus.i_req_a && bus.i_req_b) begin
                        owner_d = rr_q;
                        rr_d    = ~rr_q;
                    end else begin
                        owner_d = bus.i_req_b;
                    end
                    rw_d    = owner_d ? bus.i_rw_b   : bus.i_rw_a;
                    addr_d  = owner_d ? bus.i_addr_b : bus.i_addr_a;
                    cnt_d   = owner_d ? bus.i_len_b  : bus.i_len_a;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                bus.o_gnt_a     = !owner_q;
                bus.o_gnt_b     = owner_q;
                bus.o_ack_a     = !owner_q;
                bus.o_ack_b     = owner_q;
                bus.o_err_b     = wp_block;
                bus.o_mem_csn   = wp_block;
                bus.o_mem_rw    = rw_q;
                bus.o_mem_addr  = addr_q;
                bus.o_mem_wdata = owner_q ? bus.i_wdata_b : bus.i_wdata_a;
                state_d         = S_GAP;
            end

            S_GAP: begin
                bus.o_gnt_a    = !owner_q;
                bus.o_gnt_b    = owner_q;
                bus.o_rvalid_a = rw_q && !owner_q;
                bus.o_rvalid_b = rw_q && owner_q;
                if (cnt_q == 4'd0) begin
                    bus.o_done_a = !owner_q;
                    bus.o_done_b = owner_q;
                    state_d      = S_IDLE;
                end else if (!req_own) begin
                    rr_d    = ~owner_q;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    addr_d  = addr_q + 1'b1;
                    state_d = S_ISSUE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end
endmodule
